// File: rtl/rf_param_clr.sv
// Parametrised register file: two combinational read ports, one write port,
// optional bypass and hardwired zero entry, with a sequential clear after reset.
module rf_param_clr #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RFWE,
  input  logic [AW-1:0]    RFWA,
  input  logic [WIDTH-1:0] RFWD,
  input  logic [AW-1:0]    RFRA1,
  input  logic [AW-1:0]    RFRA2,
  output logic [WIDTH-1:0] RFRD1,
  output logic [WIDTH-1:0] RFRD2,
  output logic             RFREADY,
  output logic             RFWDROP
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            drop_q, drop_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             mem_we;
  logic [IW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic             wr_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  assign wr_ok = (state_q == S_RUN) && RFWE
              && in_range(RFWA) && !is_zero(RFWA);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    drop_d  = RFWE && !wr_ok;
    mem_we  = 1'b0;
    mem_wa  = RFWA[IW-1:0];
    mem_wd  = RFWD;
    unique case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = ptr_q[IW-1:0];
        mem_wd = '0;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        mem_we = wr_ok;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end

  // Single write port shared by the clear engine and normal writes.
  always_ff @(posedge CLK) begin
    if (!RST && mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  function automatic logic [WIDTH-1:0] rd_sel(
    input logic [AW-1:0]    a,
    input logic [WIDTH-1:0] mv
  );
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (1'b1)
      (state_q != S_RUN): r = '0;
      !in_range(a):       r = '0;
      is_zero(a):         r = '0;
      ((BYPASS != 0) && wr_ok && (RFWA == a)):
                          r = RFWD;
      default:            r = mv;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] mv1, mv2;

  assign mv1 = mem_q[RFRA1[IW-1:0]];
  assign mv2 = mem_q[RFRA2[IW-1:0]];

  always_comb begin
    RFRD1 = rd_sel(RFRA1, mv1);
    RFRD2 = rd_sel(RFRA2, mv2);
  end

  assign RFREADY = (state_q == S_RUN);
  assign RFWDROP = drop_q;

endmodule

// File: tb/tb_rf_param_clr.sv
// Bench for rf_param_clr: three configurations driven from shared stimulus,
// vector table for run-time accesses plus clear/reset sequences.
module tb_rf_param_clr;

  logic        CLK;
  logic        RST;
  logic        RFWE;
  logic [4:0]  RFWA;
  logic [31:0] RFWD;
  logic [4:0]  RFRA1;
  logic [4:0]  RFRA2;

  logic [31:0] a1, a2, b1, b2, c1, c2;
  logic        rdy_a, rdy_b, rdy_c;
  logic        drp_a, drp_b, drp_c;

  int n_cmp = 0;
  int n_bad = 0;

  rf_param_clr #(.WIDTH(32), .AW(5), .DEPTH(32), .BYPASS(1), .ZERO_R0(1)) u_a (
    .CLK(CLK), .RST(RST), .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD),
    .RFRA1(RFRA1), .RFRA2(RFRA2), .RFRD1(a1), .RFRD2(a2),
    .RFREADY(rdy_a), .RFWDROP(drp_a)
  );

  rf_param_clr #(.WIDTH(32), .AW(5), .DEPTH(32), .BYPASS(0), .ZERO_R0(0)) u_b (
    .CLK(CLK), .RST(RST), .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD),
    .RFRA1(RFRA1), .RFRA2(RFRA2), .RFRD1(b1), .RFRD2(b2),
    .RFREADY(rdy_b), .RFWDROP(drp_b)
  );

  rf_param_clr #(.WIDTH(32), .AW(5), .DEPTH(20), .BYPASS(1), .ZERO_R0(1)) u_c (
    .CLK(CLK), .RST(RST), .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD),
    .RFRA1(RFRA1), .RFRA2(RFRA2), .RFRD1(c1), .RFRD2(c2),
    .RFREADY(rdy_c), .RFWDROP(drp_c)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] ea1, ea2, eb1, eb2, ec1, ec2;
    logic [2:0]  edrop;
  } vec_t;

  vec_t v [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic measure_ready(input string tag, input int ea,
                               input int ec);
    int ta, tb, tc;
    ta = 0; tb = 0; tc = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (rdy_a && ta == 0) ta = i;
      if (rdy_b && tb == 0) tb = i;
      if (rdy_c && tc == 0) tc = i;
      if (ta != 0 && tb != 0 && tc != 0) break;
    end
    chk({tag, " rdy_a edges"}, ta, ea);
    chk({tag, " rdy_b edges"}, tb, ea);
    chk({tag, " rdy_c edges"}, tc, ec);
  endtask

  initial begin
    RST = 1'b1; RFWE = 1'b0; RFWA = '0; RFWD = '0;
    RFRA1 = 5'd7; RFRA2 = 5'd3;

    v[0]  = '{1, 7,  32'hDEADBEEF, 7,  7,
              32'hDEADBEEF, 32'hDEADBEEF, 0, 0,
              32'hDEADBEEF, 32'hDEADBEEF, 3'b000};
    v[1]  = '{0, 0,  0, 7, 7,
              32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
              32'hDEADBEEF, 32'hDEADBEEF, 3'b000};
    v[2]  = '{1, 3,  32'h12345678, 3, 3,
              32'h12345678, 32'h12345678, 0, 0,
              32'h12345678, 32'h12345678, 3'b000};
    v[3]  = '{1, 0,  32'hFFFFFFFF, 0, 3,
              0, 32'h12345678, 0, 32'h12345678,
              0, 32'h12345678, 3'b000};
    v[4]  = '{0, 0,  0, 0, 7,
              0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF,
              0, 32'hDEADBEEF, 3'b101};
    v[5]  = '{1, 25, 32'hA5A5A5A5, 25, 25,
              32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0,
              0, 0, 3'b000};
    v[6]  = '{1, 25, 32'h11111111, 25, 3,
              32'h11111111, 32'h12345678, 32'hA5A5A5A5, 32'h12345678,
              0, 32'h12345678, 3'b001};
    v[7]  = '{0, 0,  0, 25, 31,
              32'h11111111, 0, 32'h11111111, 0,
              0, 0, 3'b001};
    v[8]  = '{0, 0,  0, 3, 3,
              32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678,
              32'h12345678, 32'h12345678, 3'b000};
    v[9]  = '{1, 19, 32'hCAFEF00D, 19, 20,
              32'hCAFEF00D, 0, 0, 0,
              32'hCAFEF00D, 0, 3'b000};
    v[10] = '{0, 0,  0, 19, 19,
              32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D,
              32'hCAFEF00D, 32'hCAFEF00D, 3'b000};

    // Reset state
    repeat (3) tick();
    chk("reset rdy", {29'd0, rdy_a, rdy_b, rdy_c}, 32'd0);
    chk("reset drop", {29'd0, drp_a, drp_b, drp_c}, 32'd0);
    chk("reset rd1_a", a1, 32'd0);

    RST = 1'b0;
    measure_ready("clear1", 32, 20);

    foreach (v[i]) begin
      RFWE = v[i].we; RFWA = v[i].wa; RFWD = v[i].wd;
      RFRA1 = v[i].ra1; RFRA2 = v[i].ra2;
      @(negedge CLK);
      chk($sformatf("v%0d a1", i), a1, v[i].ea1);
      chk($sformatf("v%0d a2", i), a2, v[i].ea2);
      chk($sformatf("v%0d b1", i), b1, v[i].eb1);
      chk($sformatf("v%0d b2", i), b2, v[i].eb2);
      chk($sformatf("v%0d c1", i), c1, v[i].ec1);
      chk($sformatf("v%0d c2", i), c2, v[i].ec2);
      chk($sformatf("v%0d drop", i), {29'd0, drp_a, drp_b, drp_c},
          {29'd0, v[i].edrop});
      tick();
    end
    RFWE = 1'b0;

    // Re-enter clear with preloaded data; check reads are masked
    RST = 1'b1;
    RFRA1 = 5'd7; RFRA2 = 5'd19;
    repeat (3) tick();
    chk("rst run rdy_a", {31'd0, rdy_a}, 32'd0);
    chk("rst rd1_a", a1, 32'd0);
    chk("rst rd2_c", c2, 32'd0);

    // Write during clear is dropped
    RST = 1'b0;
    RFWE = 1'b1; RFWA = 5'd5; RFWD = 32'h77777777;
    tick();
    RFWE = 1'b0;
    chk("clr drop", {29'd0, drp_a, drp_b, drp_c}, 32'd7);
    chk("clr rd1_b", b1, 32'd0);
    tick();
    chk("clr drop end", {29'd0, drp_a, drp_b, drp_c}, 32'd0);

    // Reset when clr_ptr reaches 10 restarts the clear
    repeat (8) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    measure_ready("clear2", 32, 20);

    for (int i = 0; i < 32; i++) begin
      RFRA1 = 5'(i);
      RFRA2 = 5'(31 - i);
      @(negedge CLK);
      chk($sformatf("sweep%0d a1", i), a1, 32'd0);
      chk($sformatf("sweep%0d b1", i), b1, 32'd0);
      chk($sformatf("sweep%0d b2", i), b2, 32'd0);
      tick();
    end

    // Zero register with ZERO_R0=0 holds data; ZERO_R0=1 reads 0
    RFWE = 1'b1; RFWA = 5'd0; RFWD = 32'hFFFFFFFF; RFRA1 = 5'd0;
    tick();
    RFWE = 1'b0;
    @(negedge CLK);
    chk("r0 a1", a1, 32'd0);
    chk("r0 b1", b1, 32'hFFFFFFFF);
    chk("r0 drop", {29'd0, drp_a, drp_b, drp_c}, 32'd5);
    tick();
    chk("r0 drop end", {29'd0, drp_a, drp_b, drp_c}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_param_clr.md
Name: rf_param_clr

Overview:
Parametrised register file with two asynchronous read ports and one synchronous write port. It adds optional write-to-read bypass and an optional hardwired zero register. Reset starts a sequential clear engine that zeroes every entry one per cycle, and a ready flag reports when the clear is done. It drops into the multicycle datapath wherever the register file sits, with parameters that cover other widths and depths.

Parameters:
WIDTH, 32, data width in bits.
AW, 5, address width in bits.
DEPTH, 32, number of entries; legal range 2..2^AW.
BYPASS, 1, 1 = read of the address being written returns RFWD in the same cycle; 0 = read-first (old value).
ZERO_R0, 1, 1 = entry 0 reads as 0 and ignores writes.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
RFWE  input  1  write enable.
RFWA  input  AW  write address.
RFWD  input  WIDTH  write data.
RFRA1  input  AW  read address, port 1.
RFRA2  input  AW  read address, port 2.
RFRD1  output  WIDTH  read data, port 1 (combinational).
RFRD2  output  WIDTH  read data, port 2 (combinational).
RFREADY  output  1  high when the clear is complete and the file accepts writes.
RFWDROP  output  1  one-cycle registered pulse for a write that was rejected.

Behaviour:
- State machine has two states, CLEAR and RUN, plus a clear pointer clr_ptr of width AW.
- RST is sampled at a CLK edge. When it is high: state <= CLEAR, clr_ptr <= 0, RFREADY <= 0, RFWDROP <= 0. Memory contents are not touched while RST is held.
- In CLEAR with RST low, each edge does mem[clr_ptr] <= 0 and clr_ptr <= clr_ptr+1.
- On the edge that clears entry DEPTH-1: state <= RUN and RFREADY <= 1.
- The first cycle with RFREADY=1 is therefore exactly DEPTH edges after the first edge with RST low.
- RST asserted mid-clear restarts the clear from entry 0. RST asserted in RUN re-enters CLEAR.
- In CLEAR, RFRD1 and RFRD2 are forced to 0.
- In CLEAR, a write with RFWE=1 is discarded and RFWDROP=1 on the next cycle.
- In RUN, when RFWE=1 the edge writes mem[RFWA] <= RFWD. Exceptions, each discarded with an RFWDROP pulse:
  - RFWA >= DEPTH.
  - ZERO_R0=1 and RFWA=0.
- Read rules in RUN, applied independently to each port in this priority order:
  1. Address >= DEPTH -> 0.
  2. ZERO_R0=1 and address 0 -> 0.
  3. BYPASS=1, RFWE=1, RFWA equals the read address, and the write is accepted -> RFWD.
  4. Otherwise -> mem[address].
- Both ports may read the same address; both return the same value.
- A read and a write to the same address in one cycle:
  - BYPASS=0: the read returns the old value in that cycle and the new value from the next cycle.
  - BYPASS=1: the read returns the new value in that cycle.
- RFWDROP is high for exactly one cycle per rejected write. Back-to-back rejected writes keep it high on consecutive cycles.
- Reset values: RFREADY=0 and RFWDROP=0. RFRD1 and RFRD2 read 0 throughout CLEAR.
- Memory is a plain array with no reset in its declaration. Clearing happens only through the clear engine, one write port per cycle, so it maps to distributed RAM.

Test Plan:
- Reset clear: hold RST 3 cycles, then release, with DEPTH=32 -> RFREADY low for exactly 32 edges then high; all 32 entries read 0 on both ports. Preload nonzero data in a prior run so the clear is observable.
- Write/read with BYPASS=0: in RUN write 0xDEADBEEF to address 7 while RFRA1=7 -> RFRD1 = old value (0) that cycle and 0xDEADBEEF the next cycle. RFRA2=7 matches RFRD1.
- Bypass with BYPASS=1: write 0x12345678 to address 3 with RFRA1=RFRA2=3 -> both ports show 0x12345678 in the same cycle.
- Zero register with ZERO_R0=1: write 0xFFFFFFFF to address 0 -> RFWDROP pulses 1 cycle and RFRD1 at address 0 stays 0. With ZERO_R0=0 the same write reads back 0xFFFFFFFF.
- Drops and reset mid-clear: write during CLEAR -> RFWDROP=1 and no entry changes. Assert RST at clr_ptr=10 -> the clear restarts and RFREADY rises 32 edges after the RST release.
- Odd depth, DEPTH=20, AW=5: write to address 25 -> dropped with an RFWDROP pulse; read of address 25 -> 0. RFREADY rises 20 edges after the RST release.
